// File: rtl/tcl_egress_drain.sv
// tcl_egress_drain
// Downstream stage of the transaction layer. It pops the four per-port
// output FIFOs in round-robin order, tags each word with its port number and
// serialises the words onto one valid/ready stream. It also keeps a saturating
// count of delivered words for each port, which can be read through idx/req.
//
// Ports
//   clk, reset            single rising-edge clock, synchronous active-high reset
//   enable                1 = new pops may be issued (takes effect one cycle later)
//   empty[3:0]            empty flag of FIFO Pn (bit n)
//   dataInP0..dataInP3    FIFO data, valid the cycle after the matching pop
//   popOutP0..popOutP3    one-hot pop strobes to the FIFOs
//   data_out              {port[1:0], word} at the head of the holding buffer
//   valid_out, ready_in   output stream handshake
//   idx, req              counter read select and request
//   counterOut            counter value returned by a read (registered)
//   counterValid          counterOut is valid this cycle
module tcl_egress_drain #(
    parameter int DATA_W    = 12,
    parameter int BUF_DEPTH = 2,
    parameter int CNT_W     = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [3:0]        empty,
    input  logic [DATA_W-1:0] dataInP0,
    input  logic [DATA_W-1:0] dataInP1,
    input  logic [DATA_W-1:0] dataInP2,
    input  logic [DATA_W-1:0] dataInP3,
    output logic              popOutP0,
    output logic              popOutP1,
    output logic              popOutP2,
    output logic              popOutP3,
    output logic [DATA_W+1:0] data_out,
    output logic              valid_out,
    input  logic              ready_in,
    input  logic [1:0]        idx,
    input  logic              req,
    output logic [CNT_W-1:0]  counterOut,
    output logic              counterValid
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int OCC_W = $clog2(BUF_DEPTH + 1);

    typedef enum logic {IDLE, ACTIVE} state_e;

    state_e            state_q, state_d;
    logic [1:0]        rrPtr_q, rrPtr_d;
    logic              infl_q;
    logic [1:0]        inflPort_q;
    logic [DATA_W+1:0] buf_q [BUF_DEPTH];
    logic [PTR_W-1:0]  wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [CNT_W-1:0]  count_q [4];
    logic [CNT_W-1:0]  counterOut_q;
    logic              counterValid_q;

    logic              popFound;
    logic [1:0]        popPort;
    logic              issue;
    logic              credit;
    logic              drain;
    logic [OCC_W:0]    demand;
    logic [DATA_W-1:0] inWord;
    logic [1:0]        headPort;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(BUF_DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Outputs are forced low while reset is held so nothing stale leaks out
    // in the reset cycle itself, before the registers have been cleared.
    assign valid_out = ~reset & (occ_q != '0);
    assign data_out  = reset ? '0 : buf_q[rdPtr_q];
    assign drain     = valid_out & ready_in;
    assign headPort  = buf_q[rdPtr_q][DATA_W+1:DATA_W];

    // Credit counts the word already in flight from last cycle's pop, and
    // frees the slot being drained this cycle, so a steady ready_in sustains
    // one word per cycle without ever overrunning the buffer.
    assign demand = {1'b0, occ_q} + (OCC_W+1)'(infl_q) - (OCC_W+1)'(drain);
    assign credit = demand < (OCC_W+1)'(BUF_DEPTH);

    // Round-robin search starting at rrPtr_q, wrapping 3 -> 0.
    always_comb begin
        popFound = 1'b0;
        popPort  = rrPtr_q;
        for (int i = 0; i < 4; i++) begin
            if (!popFound && !empty[rrPtr_q + 2'(i)]) begin
                popFound = 1'b1;
                popPort  = rrPtr_q + 2'(i);
            end
        end
    end

    assign issue    = popFound & credit & (state_q == ACTIVE) & ~reset;
    assign popOutP0 = issue & (popPort == 2'd0);
    assign popOutP1 = issue & (popPort == 2'd1);
    assign popOutP2 = issue & (popPort == 2'd2);
    assign popOutP3 = issue & (popPort == 2'd3);

    always_comb begin
        inWord = dataInP0;
        case (inflPort_q)
            2'd0:    inWord = dataInP0;
            2'd1:    inWord = dataInP1;
            2'd2:    inWord = dataInP2;
            default: inWord = dataInP3;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rrPtr_d = rrPtr_q;
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        occ_d   = occ_q + OCC_W'(infl_q) - OCC_W'(drain);
        case (state_q)
            IDLE:    if (enable)  state_d = ACTIVE;
            ACTIVE:  if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (issue) begin
            rrPtr_d = popPort + 2'd1;
        end
        if (infl_q) begin
            wrPtr_d = nextPtr(wrPtr_q);
        end
        if (drain) begin
            rdPtr_d = nextPtr(rdPtr_q);
        end
    end

    // A word in flight is captured even in IDLE; reset discards it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rrPtr_q    <= '0;
            infl_q     <= 1'b0;
            inflPort_q <= '0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            occ_q      <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rrPtr_q    <= rrPtr_d;
            infl_q     <= issue;
            inflPort_q <= popPort;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            occ_q      <= occ_d;
            if (infl_q) begin
                buf_q[wrPtr_q] <= {inflPort_q, inWord};
            end
        end
    end

    // Reads sample the register before this edge's increment, so a read that
    // coincides with a delivery returns the pre-increment value.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < 4; p++) begin
                count_q[p] <= '0;
            end
            counterOut_q   <= '0;
            counterValid_q <= 1'b0;
        end else begin
            if (drain && (count_q[headPort] != '1)) begin
                count_q[headPort] <= count_q[headPort] + CNT_W'(1);
            end
            counterValid_q <= req;
            if (req) begin
                counterOut_q <= count_q[idx];
            end
        end
    end

    assign counterOut   = counterOut_q;
    assign counterValid = counterValid_q;

endmodule
